dbus_arbiter: RTL and testbench

//  Two-master arbiter for the single data/peripheral bus in front of the addr2c address decoder.

---
 rtl/dbus_pkg.sv | 13 +
 rtl/dbus_rr_pick2.sv | 14 +
 rtl/dbus_arbiter.sv | 141 ++++++++++++++
 tb/tb_dbus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared types for the data-bus arbiter: FSM state encoding and master IDs.
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dbus_state_e;

  localparam logic M_IF  = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/dbus_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last.
module dbus_rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_valid,
  output logic o_owner
);

  assign o_valid = i_req0 | i_req1;
  assign o_owner = (i_req0 & i_req1) ? ~i_last_gnt : i_req1;

endmodule

// File: rtl/dbus_arbiter.sv
// Fetch/LSU arbiter for the shared data bus: one transaction in flight,
// round-robin grant, per-access timeout forcing an error completion.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m1_req,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic [DW-1:0]   m1_wdata,
  output logic [DW-1:0]   m_rdata,
  output logic            m0_ack,
  output logic            m1_ack,
  output logic            m_err,
  output logic            s_en,
  output logic [AW-1:0]   s_addr,
  output logic            s_we,
  output logic [DW/8-1:0] s_wstrb,
  output logic [DW-1:0]   s_wdata,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_ack,
  output logic            busy
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TOUT_MAX  = {TW{1'b1}};

  dbus_state_e     r_state;
  logic            r_last_gnt;
  logic            r_owner;
  logic [TW-1:0]   r_tout;
  logic            r_s_en;
  logic [AW-1:0]   r_s_addr;
  logic            r_s_we;
  logic [DW/8-1:0] r_s_wstrb;
  logic [DW-1:0]   r_s_wdata;
  logic [DW-1:0]   r_m_rdata;
  logic            r_m0_ack;
  logic            r_m1_ack;
  logic            r_m_err;

  logic            w_pick_valid;
  logic            w_pick_owner;
  logic            w_tout_hit;

  dbus_rr_pick2 u_pick (
    .i_req0     (m0_req),
    .i_req1     (m1_req),
    .i_last_gnt (r_last_gnt),
    .o_valid    (w_pick_valid),
    .o_owner    (w_pick_owner)
  );

  assign w_tout_hit = (TIMEOUT != 0) && (r_tout == TOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_gnt <= M_IF;
      r_owner    <= M_IF;
      r_tout     <= '0;
      r_s_en     <= 1'b0;
      r_s_addr   <= '0;
      r_s_we     <= 1'b0;
      r_s_wstrb  <= '0;
      r_s_wdata  <= '0;
      r_m_rdata  <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_owner    <= w_pick_owner;
            r_last_gnt <= w_pick_owner;
            r_tout     <= '0;
            r_s_en     <= 1'b1;
            r_state    <= ACCESS;
            if (w_pick_owner == M_LSU) begin
              r_s_addr  <= m1_addr;
              r_s_we    <= m1_we;
              r_s_wstrb <= m1_wstrb;
              r_s_wdata <= m1_wdata;
            end else begin
              // Fetch is read-only, so the write side is zeroed.
              r_s_addr  <= m0_addr;
              r_s_we    <= 1'b0;
              r_s_wstrb <= '0;
              r_s_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (s_ack || w_tout_hit) begin
            // A slave ack in the timeout cycle still counts as success.
            r_m_rdata <= (s_ack && !r_s_we) ? s_rdata : '0;
            r_m_err   <= !s_ack;
            r_m0_ack  <= (r_owner == M_IF);
            r_m1_ack  <= (r_owner == M_LSU);
            r_s_en    <= 1'b0;
            r_state   <= RESP;
          end else if (r_tout != TOUT_MAX) begin
            r_tout <= r_tout + 1'b1;
          end
        end
        RESP: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_m_err  <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_s_en  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign m_rdata = r_m_rdata;
  assign m0_ack  = r_m0_ack;
  assign m1_ack  = r_m1_ack;
  assign m_err   = r_m_err;
  assign s_en    = r_s_en;
  assign s_addr  = r_s_addr;
  assign s_we    = r_s_we;
  assign s_wstrb = r_s_wstrb;
  assign s_wdata = r_s_wdata;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter against a transaction-level model of
// grant order, access duration and completion values.
module tb_dbus_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_req;
  logic [AW-1:0]   m0_addr;
  logic            m1_req;
  logic [AW-1:0]   m1_addr;
  logic            m1_we;
  logic [DW/8-1:0] m1_wstrb;
  logic [DW-1:0]   m1_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m0_ack;
  logic            m1_ack;
  logic            m_err;
  logic            s_en;
  logic [AW-1:0]   s_addr;
  logic            s_we;
  logic [DW/8-1:0] s_wstrb;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   s_rdata;
  logic            s_ack;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  int last_gnt = 0;

  dbus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_we    (m1_we),
    .m1_wstrb (m1_wstrb),
    .m1_wdata (m1_wdata),
    .m_rdata  (m_rdata),
    .m0_ack   (m0_ack),
    .m1_ack   (m1_ack),
    .m_err    (m_err),
    .s_en     (s_en),
    .s_addr   (s_addr),
    .s_we     (s_we),
    .s_wstrb  (s_wstrb),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ack    (s_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int who);
    if (who == 0) begin
      m0_req  = 1'b1;
      m0_addr = $urandom;
    end else begin
      m1_req   = 1'b1;
      m1_addr  = $urandom;
      m1_we    = 1'($urandom_range(0, 1));
      m1_wstrb = 4'($urandom);
      m1_wdata = $urandom;
    end
  endtask

  // Entered in an idle cycle with requests already driven; returns in the
  // idle cycle following the completion (or one cycle later if nobody asked).
  task automatic run_txn(input int delay, input logic [DW-1:0] sdata);
    int owner;
    int dur;
    bit acked;
    logic [AW-1:0]   e_addr;
    logic            e_we;
    logic [DW/8-1:0] e_wstrb;
    logic [DW-1:0]   e_wdata;
    logic [DW-1:0]   e_rdata;
    if (!m0_req && !m1_req) begin
      s_ack = 1'($urandom_range(0, 1));
      step();
      check_eq("idle_busy", busy, 0);
      check_eq("idle_s_en", s_en, 0);
      s_ack = 1'b0;
      return;
    end
    if (m0_req && m1_req) owner = 1 - last_gnt;
    else                  owner = m1_req ? 1 : 0;
    last_gnt = owner;
    e_addr  = owner ? m1_addr : m0_addr;
    e_we    = owner ? m1_we : 1'b0;
    e_wstrb = owner ? m1_wstrb : '0;
    e_wdata = owner ? m1_wdata : '0;
    acked   = (TIMEOUT == 0) || (delay <= TIMEOUT);
    dur     = acked ? delay : TIMEOUT;
    e_rdata = (acked && !e_we) ? sdata : '0;
    $display("txn owner=m%0d addr=%08h we=%0d cycles=%0d err=%0d", owner, e_addr, e_we, dur, !acked);
    s_ack = 1'($urandom_range(0, 1));
    step();
    for (int i = 1; i <= dur; i++) begin
      check_eq("acc_s_en", s_en, 1);
      check_eq("acc_busy", busy, 1);
      check_eq("acc_s_addr", s_addr, e_addr);
      check_eq("acc_s_we", s_we, e_we);
      check_eq("acc_s_wstrb", s_wstrb, e_wstrb);
      check_eq("acc_s_wdata", s_wdata, e_wdata);
      check_eq("acc_no_ack", {m0_ack, m1_ack}, 0);
      s_ack   = acked && (i == dur);
      s_rdata = s_ack ? sdata : $urandom;
      if (owner == 0) begin
        m0_addr = $urandom;
        if ($urandom_range(0, 3) == 0) m0_req = 1'b0;
      end else begin
        m1_addr  = $urandom;
        m1_wdata = $urandom;
        if ($urandom_range(0, 3) == 0) m1_req = 1'b0;
      end
      step();
    end
    check_eq("resp_s_en", s_en, 0);
    check_eq("resp_busy", busy, 1);
    check_eq("resp_m0_ack", m0_ack, owner == 0);
    check_eq("resp_m1_ack", m1_ack, owner == 1);
    check_eq("resp_rdata", m_rdata, e_rdata);
    check_eq("resp_err", m_err, !acked);
    if (owner == 0) m0_req = 1'b0;
    else            m1_req = 1'b0;
    s_ack   = 1'($urandom_range(0, 1));
    s_rdata = $urandom;
    step();
    check_eq("post_acks", {m0_ack, m1_ack, m_err}, 0);
    check_eq("post_rdata", m_rdata, e_rdata);
    check_eq("post_busy", busy, 0);
    check_eq("post_s_en", s_en, 0);
    s_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_addr = '0;
    m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_wstrb = '0; m1_wdata = '0;
    s_rdata = '0; s_ack = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_s_en", s_en, 0);
    check_eq("rst_acks", {m0_ack, m1_ack, m_err}, 0);
    check_eq("rst_rdata", m_rdata, 0);
    check_eq("rst_s_bus", {s_addr, s_we, s_wstrb, s_wdata}, 0);
    rst = 1'b0;
    step();

    // m1 read acked in its 2nd access cycle
    m1_req = 1'b1; m1_addr = 32'h2000_0010; m1_we = 1'b0;
    run_txn(2, 32'hDEAD_BEEF);

    // Both masters requesting continuously: grants must alternate
    for (int r = 0; r < 4; r++) begin
      if (!m0_req) new_req(0);
      if (!m1_req) new_req(1);
      run_txn(1, $urandom);
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // m1 write
    m1_req = 1'b1; m1_addr = 32'h1000_0004; m1_we = 1'b1;
    m1_wstrb = 4'hF; m1_wdata = 32'h5;
    run_txn(3, 32'h1234_5678);

    // Unmapped address: full timeout
    m0_req = 1'b1; m0_addr = 32'h6000_0000;
    run_txn(1000, 32'hFFFF_FFFF);

    // Ack in the last allowed cycle wins over the timeout
    m1_req = 1'b1; m1_addr = 32'h6000_0004; m1_we = 1'b0;
    run_txn(TIMEOUT, 32'hCAFE_F00D);

    // Reset two cycles into an access aborts it without an ack
    new_req(1);
    step();
    step();
    rst = 1'b1;
    step();
    check_eq("abort_s_en", s_en, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_acks", {m0_ack, m1_ack}, 0);
    rst = 1'b0; m1_req = 1'b0;
    last_gnt = 0;
    step();
    check_eq("abort_idle_acks", {m0_ack, m1_ack}, 0);

    // First tie after reset goes to m1
    new_req(0);
    new_req(1);
    run_txn(2, $urandom);
    m0_req = 1'b0;

    for (int r = 0; r < 300; r++) begin
      if (!m0_req && $urandom_range(0, 1) == 1) new_req(0);
      if (!m1_req && $urandom_range(0, 1) == 1) new_req(1);
      run_txn($urandom_range(1, TIMEOUT + 3), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
